mult_seq_unit: RTL

Sequential 32×32 multiplier producing a 64-bit product into HI/LO registers for the processor's `mult`/`multu` instructions. It sits directly downstream of the 32-bit ripple adder stage: each iteration consumes one 33-bit add result (sum plus carry-out) and shifts it into the partial-product register. The block needs one start pulse and delivers a result after a fixed 33-cycle latency, with a busy/done handshake to the control unit.

---
 rtl/mult_seq_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/mult_seq_unit.sv
// Sequential 32x32 shift-add multiplier (signed/unsigned) with a busy/done handshake.
// Each start produces the 64-bit product in hi/lo exactly 33 cycles later.
module mult_seq_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] mcand_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic [4:0]  count_q;
  logic        neg_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] abs_a_d;
  logic [31:0] abs_b_d;
  logic [32:0] sum_d;
  logic [63:0] prod_d;

  // Magnitudes: 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    abs_a_d = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    abs_b_d = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
    sum_d   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q}) : {1'b0, acc_hi_q};
    prod_d  = neg_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= abs_a_d;
            acc_hi_q <= '0;
            acc_lo_q <= abs_b_d;
            neg_q    <= is_signed & (op_a[31] ^ op_b[31]);
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Carry-out of the add becomes the new MSB of the partial product.
          {acc_hi_q, acc_lo_q} <= {sum_d, acc_lo_q[31:1]};
          count_q              <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= prod_d[63:32];
          lo_q    <= prod_d[31:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          count_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
